pll_lock_sequencer: RTL and testbench

- Sequences bring-up of the ring-oscillator frequency-locked loop: reset release, settle, lock qualification and clock-mux selection.
- Runs in the reference-oscillator domain.
- Measures PLL output frequency via a pre-divided, pre-synchronized tick (one pulse per 16 PLL cycles) against the programmed divide ratio.
- Drives the PLL control pins and the core clock select; falls back to error status after repeated failed lock attempts. DCO (open-loop trim) mode is also supported.

---
 rtl/pll_lock_sequencer_if.sv | 48 ++++
 rtl/pll_lock_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_if.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer_if
//   Groups the configuration inputs, the frequency tick and the PLL control /
//   status outputs of the PLL lock sequencer into one bundle.
//
//   Signal semantics (no valid/ready pairs exist on this block):
//     - cfg_* are levels. cfg_div/cfg_dco/cfg_trim are sampled only on the
//       cycle the sequencer leaves IDLE; later changes are ignored.
//     - pll_tick is a single-cycle pulse and is counted on every cycle it is 1.
//     - All outputs are registered. meas_count changes only on the last cycle
//       of a measurement window; state is the live FSM code for observers.
//
//   Modports:
//     master : the sequencer (drives the PLL pins and status)
//     slave  : the environment (drives config and the tick)
// -----------------------------------------------------------------------------
interface pll_lock_sequencer_if #(
  parameter int WIN_LOG2 = 8
);
  logic                cfg_enable;
  logic [4:0]          cfg_div;
  logic                cfg_dco;
  logic [25:0]         cfg_trim;
  logic                pll_tick;

  logic                pll_enable;
  logic                pll_resetb;
  logic [4:0]          pll_div;
  logic                pll_dco;
  logic [25:0]         pll_trim;
  logic                clk_sel;
  logic                locked;
  logic                fail;
  logic [2:0]          state;
  logic [WIN_LOG2+1:0] meas_count;

  modport master (
    input  cfg_enable, cfg_div, cfg_dco, cfg_trim, pll_tick,
    output pll_enable, pll_resetb, pll_div, pll_dco, pll_trim,
           clk_sel, locked, fail, state, meas_count
  );

  modport slave (
    output cfg_enable, cfg_div, cfg_dco, cfg_trim, pll_tick,
    input  pll_enable, pll_resetb, pll_div, pll_dco, pll_trim,
           clk_sel, locked, fail, state, meas_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//   Brings up the ring-oscillator frequency-locked loop from the reference
//   oscillator domain: holds the PLL in reset, lets it settle, then counts
//   pre-divided PLL ticks (one per 16 PLL cycles) over fixed windows and
//   compares against the programmed ratio to qualify lock and switch the core
//   clock mux. Repeated bad windows end in a sticky FAIL. DCO mode skips the
//   lock loop and selects the PLL clock right after settling.
//
// Ports:
//   clock  : reference clock
//   reset  : synchronous, active-high
//   bus    : pll_lock_sequencer_if.master (config, tick, PLL pins, status)
//
// State codes: IDLE=0 RST=1 SETTLE=2 MEASURE=3 LOCKED=4 DCO=5 FAIL=6
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int WIN_LOG2     = 8,
  parameter int RST_CYC      = 4,
  parameter int SETTLE_CYC   = 64,
  parameter int TOL          = 4,
  parameter int LOCK_WINDOWS = 2,
  parameter int MAX_RETRY    = 3
) (
  input logic                  clock,
  input logic                  reset,
  pll_lock_sequencer_if.master bus
);

  localparam int CW     = WIN_LOG2 + 2;
  localparam int PH_MAX = (SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int GW     = $clog2(LOCK_WINDOWS + 1);
  localparam int RW     = $clog2(MAX_RETRY + 1);

  localparam logic [PW-1:0]       RST_LAST    = PW'(RST_CYC - 1);
  localparam logic [PW-1:0]       SETTLE_LAST = PW'(SETTLE_CYC - 1);
  localparam logic [WIN_LOG2-1:0] WIN_LAST    = '1;
  localparam logic [CW-1:0]       TOL_V       = CW'(TOL);
  localparam logic [GW-1:0]       LOCK_V      = GW'(LOCK_WINDOWS);
  localparam logic [RW-1:0]       RETRY_V     = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_DCO     = 3'd5,
    ST_FAIL    = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ph_q, ph_d;         // cycle counter for RST / SETTLE
  logic [WIN_LOG2-1:0] win_q, win_d;       // position inside the window
  logic [CW-1:0]       cnt_q, cnt_d;       // ticks seen in the current window
  logic [GW-1:0]       good_q, good_d;     // consecutive good windows
  logic [RW-1:0]       retry_q, retry_d;   // cumulative bad windows
  logic [CW-1:0]       meas_q, meas_d;
  logic [4:0]          div_q, div_d;
  logic                dco_q, dco_d;
  logic [25:0]         trim_q, trim_d;
  logic                pll_enable_q, pll_enable_d;
  logic                pll_resetb_q, pll_resetb_d;
  logic                clk_sel_q, clk_sel_d;
  logic                locked_q, locked_d;
  logic                fail_q, fail_d;

  logic [CW-1:0]       cnt_inc;
  logic [CW-1:0]       expected;
  logic [CW-1:0]       diff;
  logic                win_good;
  logic                win_end;

  // Window arithmetic. cnt_inc already contains this cycle's tick so the
  // final cycle's tick lands in the completed window.
  always_comb begin
    cnt_inc  = (bus.pll_tick && (cnt_q != '1)) ? cnt_q + CW'(1) : cnt_q;
    expected = CW'(div_q) << (WIN_LOG2 - 4);
    diff     = (cnt_inc >= expected) ? (cnt_inc - expected) : (expected - cnt_inc);
    win_good = (diff <= TOL_V);
    win_end  = (win_q == WIN_LAST);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    good_d  = good_q;
    retry_d = retry_q;
    meas_d  = meas_q;
    div_d   = div_q;
    dco_d   = dco_q;
    trim_d  = trim_q;

    case (state_q)
      ST_IDLE: begin
        good_d  = '0;
        retry_d = '0;
        if (bus.cfg_enable) begin
          div_d   = bus.cfg_div;
          dco_d   = bus.cfg_dco;
          trim_d  = bus.cfg_trim;
          ph_d    = '0;
          state_d = ST_RST;
        end
      end

      ST_RST: begin
        if (ph_q == RST_LAST) begin
          ph_d    = '0;
          state_d = ST_SETTLE;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end

      ST_SETTLE: begin
        if (ph_q == SETTLE_LAST) begin
          ph_d = '0;
          if (dco_q) begin
            state_d = ST_DCO;
          end else begin
            win_d   = '0;
            cnt_d   = '0;
            good_d  = '0;
            state_d = ST_MEASURE;
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end

      ST_MEASURE, ST_LOCKED: begin
        // Window counter wraps naturally from all-ones to zero.
        win_d = win_q + WIN_LOG2'(1);
        cnt_d = cnt_inc;
        if (win_end) begin
          meas_d = cnt_inc;
          cnt_d  = '0;
          if (state_q == ST_MEASURE) begin
            if (win_good) begin
              good_d = good_q + GW'(1);
              if ((good_q + GW'(1)) == LOCK_V) begin
                retry_d = '0;
                state_d = ST_LOCKED;
              end
            end else begin
              good_d  = '0;
              retry_d = retry_q + RW'(1);
              if ((retry_q + RW'(1)) == RETRY_V) begin
                state_d = ST_FAIL;
              end
            end
          end else if (!win_good) begin
            // Losing lock counts as the first retry of the new attempt.
            good_d  = '0;
            retry_d = RW'(1);
            state_d = ST_MEASURE;
          end
        end
      end

      default: begin
        // DCO and FAIL hold until cfg_enable drops.
      end
    endcase

    // Dropping enable aborts from anywhere; the partial window is discarded
    // but the last completed measurement and latched config are kept.
    if (!bus.cfg_enable) begin
      state_d = ST_IDLE;
      ph_d    = '0;
      win_d   = '0;
      cnt_d   = '0;
      good_d  = '0;
      retry_d = '0;
    end
  end

  // Output decode from the next state so the registered pins line up with
  // the registered state code.
  always_comb begin
    pll_enable_d = 1'b0;
    pll_resetb_d = 1'b0;
    clk_sel_d    = 1'b0;
    locked_d     = 1'b0;
    fail_d       = 1'b0;
    case (state_d)
      ST_RST: begin
        pll_enable_d = 1'b1;
      end
      ST_SETTLE, ST_MEASURE: begin
        pll_enable_d = 1'b1;
        pll_resetb_d = 1'b1;
      end
      ST_LOCKED: begin
        pll_enable_d = 1'b1;
        pll_resetb_d = 1'b1;
        clk_sel_d    = 1'b1;
        locked_d     = 1'b1;
      end
      ST_DCO: begin
        pll_enable_d = 1'b1;
        pll_resetb_d = 1'b1;
        clk_sel_d    = 1'b1;
      end
      ST_FAIL: begin
        fail_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ph_q         <= '0;
      win_q        <= '0;
      cnt_q        <= '0;
      good_q       <= '0;
      retry_q      <= '0;
      meas_q       <= '0;
      div_q        <= '0;
      dco_q        <= 1'b0;
      trim_q       <= '0;
      pll_enable_q <= 1'b0;
      pll_resetb_q <= 1'b0;
      clk_sel_q    <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      retry_q      <= retry_d;
      meas_q       <= meas_d;
      div_q        <= div_d;
      dco_q        <= dco_d;
      trim_q       <= trim_d;
      pll_enable_q <= pll_enable_d;
      pll_resetb_q <= pll_resetb_d;
      clk_sel_q    <= clk_sel_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.pll_enable = pll_enable_q;
  assign bus.pll_resetb = pll_resetb_q;
  assign bus.pll_div    = div_q;
  assign bus.pll_dco    = dco_q;
  assign bus.pll_trim   = trim_q;
  assign bus.clk_sel    = clk_sel_q;
  assign bus.locked     = locked_q;
  assign bus.fail       = fail_q;
  assign bus.state      = state_q;
  assign bus.meas_count = meas_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Each driven cycle advances a behavioural model of the sequencer and pushes
//   the full expected output vector into exp_q; a monitor pops one entry after
//   every clock edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam int W            = 8;
  localparam int RST_CYC      = 4;
  localparam int SETTLE_CYC   = 64;
  localparam int TOL          = 4;
  localparam int LOCK_WINDOWS = 2;
  localparam int MAX_RETRY    = 3;
  localparam int WIN          = 1 << W;
  localparam int MW           = W + 2;
  localparam int OW           = 40 + MW;

  localparam int M_COUNT  = 0;  // exactly arg ticks per window, evenly spread
  localparam int M_PERIOD = 1;  // one tick every arg cycles
  localparam int M_RAND   = 2;  // tick with arg percent probability

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pll_lock_sequencer_if #(.WIN_LOG2(W)) bus ();

  pll_lock_sequencer #(
    .WIN_LOG2(W), .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC), .TOL(TOL),
    .LOCK_WINDOWS(LOCK_WINDOWS), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] mon_want;
  logic [OW-1:0] mon_got;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  // phase uses the published state codes; everything else is plain integers.
  int         m_phase = 0;
  int         m_t     = 0;
  int         m_wpos  = 0;
  int         m_ticks = 0;
  int         m_good  = 0;
  int         m_retry = 0;
  int         m_meas  = 0;
  logic [4:0]  m_div  = '0;
  logic        m_dco  = 1'b0;
  logic [25:0] m_trim = '0;

  // stimulus-side configuration
  logic        c_en   = 1'b0;
  logic [4:0]  c_div  = '0;
  logic        c_dco  = 1'b0;
  logic [25:0] c_trim = '0;

  function automatic logic [OW-1:0] model_out();
    logic pe, prb, cs, lk, fl;
    pe  = (m_phase >= 1) && (m_phase <= 5);
    prb = (m_phase >= 2) && (m_phase <= 5);
    cs  = (m_phase == 4) || (m_phase == 5);
    lk  = (m_phase == 4);
    fl  = (m_phase == 6);
    return {pe, prb, m_div, m_dco, m_trim, cs, lk, fl, 3'(m_phase), MW'(m_meas)};
  endfunction

  task automatic window_step(input logic tick);
    int err;
    if (tick) m_ticks++;
    if (m_wpos == WIN - 1) begin
      err = m_ticks - int'(m_div) * (WIN / 16);
      if (err < 0) err = -err;
      m_meas  = m_ticks;
      m_ticks = 0;
      m_wpos  = 0;
      if (err <= TOL) begin
        if (m_phase == 3) begin
          m_good++;
          if (m_good == LOCK_WINDOWS) begin
            m_phase = 4;
            m_retry = 0;
          end
        end
      end else begin
        m_good = 0;
        if (m_phase == 4) begin
          m_phase = 3;
          m_retry = 1;
        end else begin
          m_retry++;
          if (m_retry == MAX_RETRY) m_phase = 6;
        end
      end
    end else begin
      m_wpos++;
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic tick);
    if (rst) begin
      m_phase = 0; m_t = 0; m_wpos = 0; m_ticks = 0; m_good = 0; m_retry = 0;
      m_meas = 0; m_div = '0; m_dco = 1'b0; m_trim = '0;
    end else if (!en) begin
      m_phase = 0; m_t = 0; m_wpos = 0; m_ticks = 0; m_good = 0; m_retry = 0;
    end else begin
      case (m_phase)
        0: begin
          m_div = c_div; m_dco = c_dco; m_trim = c_trim;
          m_phase = 1; m_t = 0;
        end
        1: if (m_t == RST_CYC - 1) begin m_phase = 2; m_t = 0; end else m_t++;
        2: begin
          if (m_t == SETTLE_CYC - 1) begin
            m_t = 0;
            if (m_dco) m_phase = 5;
            else begin m_phase = 3; m_wpos = 0; m_ticks = 0; m_good = 0; end
          end else m_t++;
        end
        3, 4: window_step(tick);
        default: ;
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic pick_tick(input int mode, input int arg);
    case (mode)
      M_COUNT:  return ((m_wpos + 1) * arg / WIN) != (m_wpos * arg / WIN);
      M_PERIOD: return (cyc % arg) == 0;
      default:  return $urandom_range(0, 99) < arg;
    endcase
  endfunction

  task automatic drive(input logic rst, input logic tick);
    @(negedge clock);
    reset          = rst;
    bus.cfg_enable = c_en;
    bus.cfg_div    = c_div;
    bus.cfg_dco    = c_dco;
    bus.cfg_trim   = c_trim;
    bus.pll_tick   = tick;
    model_step(rst, c_en, tick);
    exp_q.push_back(model_out());
    cyc++;
  endtask

  task automatic run(input int n, input int mode, input int arg);
    for (int i = 0; i < n; i++) drive(1'b0, pick_tick(mode, arg));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
  endtask

  // Enable and run through RST + SETTLE; a lock-loop run ends at window start.
  task automatic start_seq();
    c_en = 1'b1;
    run(1 + RST_CYC + SETTLE_CYC, M_COUNT, 0);
  endtask

  task automatic stop_seq();
    c_en = 1'b0;
    run(2, M_RAND, 30);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clock) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_want = exp_q.pop_front();
      mon_got  = {bus.pll_enable, bus.pll_resetb, bus.pll_div, bus.pll_dco,
                  bus.pll_trim, bus.clk_sel, bus.locked, bus.fail, bus.state,
                  bus.meas_count};
      total++;
      if (mon_got !== mon_want) begin
        bad++;
        $display("FAIL outputs t=%0t got=%h want=%h (en,rstb,div,dco,trim,sel,lock,fail,state,meas)",
                 $time, mon_got, mon_want);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int tol_counts[7];
    int div;
    int n;
    bus.cfg_enable = 1'b0;
    bus.cfg_div    = '0;
    bus.cfg_dco    = 1'b0;
    bus.cfg_trim   = '0;
    bus.pll_tick   = 1'b0;

    do_reset(3);

    // Nominal lock: div 8, tick every 2 cycles -> 128 per window.
    c_div = 5'd8; c_dco = 1'b0; c_trim = 26'($urandom);
    start_seq();
    run(3 * WIN, M_COUNT, 128);

    // Rate drop to one tick per 3 cycles loses lock, then relock.
    run(WIN, M_PERIOD, 3);
    run(3 * WIN, M_COUNT, 128);
    stop_seq();

    // Tolerance edges with div 8 (expected 128, TOL 4).
    tol_counts = '{132, 133, 124, 123, 128, 128, 128};
    start_seq();
    foreach (tol_counts[k]) run(WIN, M_COUNT, tol_counts[k]);
    stop_seq();

    // No ticks: three bad windows then FAIL, cleared by dropping enable.
    start_seq();
    run(3 * WIN, M_COUNT, 0);
    run(20, M_COUNT, 0);
    stop_seq();

    // DCO mode: ticks are ignored.
    c_dco = 1'b1; c_trim = 26'h3FFFFFF;
    start_seq();
    run(100, M_RAND, 50);
    stop_seq();
    c_dco = 1'b0;

    // Enable dropped mid-window, then reset while locked.
    start_seq();
    run(100, M_COUNT, 128);
    stop_seq();
    start_seq();
    run(3 * WIN, M_COUNT, 128);
    do_reset(2);
    run(10, M_COUNT, 128);
    stop_seq();

    // Randomized runs, including div 0 and config changes mid-run.
    for (int it = 0; it < 8; it++) begin
      div    = (it == 0) ? 0 : int'($urandom_range(0, 31));
      c_div  = 5'(div);
      c_dco  = (it == 3);
      c_trim = 26'($urandom);
      c_en   = 1'b1;
      run(1, M_COUNT, 0);
      c_div  = 5'($urandom_range(0, 31));
      c_trim = 26'($urandom);
      c_dco  = 1'($urandom_range(0, 1));
      run(RST_CYC + SETTLE_CYC, M_COUNT, 0);
      n = 0;
      for (int w = 0; w < 5; w++) begin
        if (it == 0) n = int'($urandom_range(0, 6));
        else n = div * 16 + int'($urandom_range(0, 16)) - 8;
        if (n < 0) n = 0;
        if (n > WIN) n = WIN;
        if ($urandom_range(0, 9) == 0) run(WIN, M_RAND, 50);
        else run(WIN, M_COUNT, n);
      end
      if ($urandom_range(0, 1) == 1) run(int'($urandom_range(1, WIN - 1)), M_COUNT, n);
      stop_seq();
    end

    @(posedge clock);
    #4;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
